lcd_responder: RTL and testbench
================================

LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 Parameter CMD_CYCLES, default 4: busy cycles after any non-clear, non-home accepted transfer.
REQ-002 Parameter HOME_CYCLES, default 100: busy cycles after return-home.
REQ-003 clk  in  1  single system clock; all logic on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 lcd_e  in  1  enable strobe from the initiator; a transfer commits on its falling edge.
REQ-006 lcd_rs  in  1  0 = instruction, 1 = data.
REQ-007 lcd_rw  in  1  0 = write, 1 = read.
REQ-008 lcd_data  in  8  write data / instruction byte.
REQ-009 lcd_dout  out  8  read data; lcd_dout_en  out  1  high while lcd_rw=1 and lcd_e=1.
REQ-010 rd_addr  in  7  scan port address; rd_data  out  8  DDRAM[rd_addr], registered, 1-cycle latency.
REQ-011 busy  out  1; ac  out  7 address counter; disp_on, cursor_on, blink_on, inc_mode  out  1 each.
REQ-012 err_busy  out  1 sticky: transfer arrived while busy; err_unsup  out  1 sticky: unsupported command.

Function
REQ-013 lcd_e SHALL be registered once; a strobe is e_q=1 and lcd_e=0; rs/rw/data SHALL be sampled on that same cycle.
REQ-014 DDRAM SHALL hold 80 bytes: line 1 addresses 0x00-0x27, line 2 addresses 0x40-0x67.
REQ-015 States SHALL be CLEAR, IDLE and BUSY.
REQ-016 CLEAR: one byte written per cycle with 0x20, addresses 0x00-0x27 then 0x40-0x67 (80 cycles); at the end ac=0x00, inc_mode=1, go to IDLE.
REQ-017 BUSY: a counter loaded on entry; return to IDLE when it expires.
REQ-018 In IDLE, instruction writes SHALL decode by leading one:
- 0x01: clear, go to CLEAR.
- 0x02/0x03: ac=0, go to BUSY for HOME_CYCLES.
- 0x04-0x07: inc_mode=bit1; bit0=1 sets err_unsup.
- 0x08-0x0F: disp_on=bit2, cursor_on=bit1, blink_on=bit0.
- 0x10-0x1F: cursor/display shift; set err_unsup; ac unchanged.
- 0x20-0x3F: function set; accepted, no state effect.
- 0x40-0x7F: CGRAM address; set err_unsup.
- 0x80-0xFF: ac=data[6:0], except 0x28-0x3F loads 0x40 and 0x68-0x7F loads 0x00.
- 0x00: ignored; no busy.
REQ-019 A data write SHALL store lcd_data at DDRAM[ac], then advance ac.
REQ-020 A data read SHALL present DDRAM[ac] on lcd_dout while e is high; on the strobe, ac advances.
REQ-021 An instruction read SHALL present {busy, ac} on lcd_dout; it is legal while busy and does not set err_busy.
REQ-022 Advance, inc_mode=1: 0x27->0x40, 0x67->0x00, otherwise +1.
REQ-023 Advance, inc_mode=0: 0x00->0x67, 0x40->0x27, otherwise -1.
REQ-024 After every accepted transfer except clear, home and 0x00, go to BUSY for CMD_CYCLES.
REQ-025 busy SHALL be 1 in CLEAR and BUSY, and 0 in IDLE.
REQ-026 A write strobe while busy SHALL be discarded and set err_busy; a read strobe while busy SHALL return data without advancing ac.
REQ-027 The scan port SHALL be independent of the protocol side; a scan read of the address written on the same cycle returns the old byte.

Reset
REQ-028 While rst=1: ac=0x00, inc_mode=1, disp_on=0, cursor_on=0, blink_on=0, err_busy=0, err_unsup=0, lcd_dout=0x00, rd_data=0x00, e_q=0, state forced to CLEAR with fill index 0.
REQ-029 After rst falls, busy SHALL stay 1 for 80 cycles (the fill), then drop.
REQ-030 rst asserted mid-CLEAR or mid-BUSY SHALL restart the fill from index 0.

Verification
REQ-031 Reset, wait 80 cycles -> busy=0; scan 0x00, 0x27, 0x40, 0x67 -> all 0x20.
REQ-032 Write 0x38, 0x0C, 0x06, 0x80, then data 0x31 0x2B 0x32, honoring busy -> DDRAM[0..2] = 31 2B 32; ac=0x03; disp_on=1, cursor_on=0.
REQ-033 Write 0xA7 then data 0x41 0x42 -> DDRAM[0x27]=0x41, DDRAM[0x40]=0x42, ac=0x41.
REQ-034 Write 0x04, 0xC0, data 0x5A -> DDRAM[0x40]=0x5A, ac=0x27.
REQ-035 Write 0x01, then a data strobe 10 cycles later -> strobe discarded, err_busy=1; busy drops after 80 cycles; all cells 0x20.
REQ-036 Instruction read during a HOME_CYCLES busy -> lcd_dout=0x80 with ac=0; write 0x18 -> err_unsup=1.

Source files
------------

// File: rtl/lcd_responder.sv
// HD44780-style LCD responder: 80-byte DDRAM, address counter, busy timing.
// A transfer commits on the falling edge of lcd_e; a separate scan port reads DDRAM.
module lcd_responder #(
  parameter int CMD_CYCLES  = 4,
  parameter int HOME_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  output logic [7:0] lcd_dout,
  output logic       lcd_dout_en,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       err_busy,
  output logic       err_unsup
);

  typedef enum logic [1:0] {CLEAR, IDLE, BUSY} state_t;

  localparam logic [15:0] CMD_LD  = 16'(CMD_CYCLES - 1);
  localparam logic [15:0] HOME_LD = 16'(HOME_CYCLES - 1);

  state_t      state, state_d;
  logic        e_q, strobe, go_cmd;
  logic [6:0]  fill, fill_d;
  logic [15:0] cnt, cnt_d;
  logic [6:0]  ac_d;
  logic        inc_d, disp_d, cur_d, blink_d, eb_d, eu_d;
  logic        wr_en;
  logic [6:0]  wr_idx, rd_idx;
  logic [7:0]  wr_val;
  logic [7:0]  mem [0:79];

  // line 1 occupies cells 0-39, line 2 (0x40-0x67) cells 40-79
  function automatic logic [6:0] idx(input logic [6:0] a);
    return a[6] ? 7'd40 + {1'b0, a[5:0]} : {1'b0, a[5:0]};
  endfunction

  function automatic logic [6:0] adv(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h00) return 7'h67;
    if (a == 7'h40) return 7'h27;
    return a - 7'd1;
  endfunction

  function automatic logic [6:0] set_ac(input logic [6:0] v);
    if (v[5:0] >= 6'h28) return v[6] ? 7'h00 : 7'h40;
    return v;
  endfunction

  assign strobe      = e_q & ~lcd_e;
  assign busy        = (state != IDLE);
  assign lcd_dout_en = lcd_rw & lcd_e;
  assign rd_idx      = idx(rd_addr);

  always_comb begin
    state_d = state;
    fill_d  = fill;
    cnt_d   = cnt;
    ac_d    = ac;
    inc_d   = inc_mode;
    disp_d  = disp_on;
    cur_d   = cursor_on;
    blink_d = blink_on;
    eb_d    = err_busy;
    eu_d    = err_unsup;
    wr_en   = 1'b0;
    wr_idx  = fill;
    wr_val  = 8'h20;
    go_cmd  = 1'b0;
    unique case (state)
      CLEAR: begin
        wr_en  = 1'b1;
        fill_d = fill + 7'd1;
        if (fill == 7'd79) begin
          state_d = IDLE;
          fill_d  = 7'd0;
          ac_d    = 7'h00;
          inc_d   = 1'b1;
        end
      end
      BUSY: begin
        if (cnt == 16'd0) state_d = IDLE;
        else cnt_d = cnt - 16'd1;
      end
      IDLE: begin
        if (strobe && lcd_rs) begin
          if (!lcd_rw) begin
            wr_en  = 1'b1;
            wr_idx = idx(ac);
            wr_val = lcd_data;
          end
          ac_d   = adv(ac, inc_mode);
          go_cmd = 1'b1;
        end else if (strobe && !lcd_rw) begin
          unique case (1'b1)
            lcd_data[7]: begin
              ac_d   = set_ac(lcd_data[6:0]);
              go_cmd = 1'b1;
            end
            (lcd_data[7:6] == 2'b01): begin
              eu_d   = 1'b1;
              go_cmd = 1'b1;
            end
            (lcd_data[7:5] == 3'b001): go_cmd = 1'b1;
            (lcd_data[7:4] == 4'b0001): begin
              eu_d   = 1'b1;
              go_cmd = 1'b1;
            end
            (lcd_data[7:3] == 5'b00001): begin
              disp_d  = lcd_data[2];
              cur_d   = lcd_data[1];
              blink_d = lcd_data[0];
              go_cmd  = 1'b1;
            end
            (lcd_data[7:2] == 6'b000001): begin
              inc_d  = lcd_data[1];
              eu_d   = err_unsup | lcd_data[0];
              go_cmd = 1'b1;
            end
            (lcd_data[7:1] == 7'b0000001): begin
              ac_d    = 7'h00;
              state_d = BUSY;
              cnt_d   = HOME_LD;
            end
            (lcd_data == 8'h01): begin
              state_d = CLEAR;
              fill_d  = 7'd0;
            end
            default: ;
          endcase
        end
      end
      default: state_d = CLEAR;
    endcase
    if (go_cmd) begin
      state_d = BUSY;
      cnt_d   = CMD_LD;
    end
    if (strobe && !lcd_rw && busy) eb_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      fill      <= 7'd0;
      cnt       <= 16'd0;
      e_q       <= 1'b0;
      ac        <= 7'h00;
      inc_mode  <= 1'b1;
      disp_on   <= 1'b0;
      cursor_on <= 1'b0;
      blink_on  <= 1'b0;
      err_busy  <= 1'b0;
      err_unsup <= 1'b0;
      lcd_dout  <= 8'h00;
      rd_data   <= 8'h00;
    end else begin
      state     <= state_d;
      fill      <= fill_d;
      cnt       <= cnt_d;
      e_q       <= lcd_e;
      ac        <= ac_d;
      inc_mode  <= inc_d;
      disp_on   <= disp_d;
      cursor_on <= cur_d;
      blink_on  <= blink_d;
      err_busy  <= eb_d;
      err_unsup <= eu_d;
      if (lcd_rw && lcd_e)
        lcd_dout <= lcd_rs ? mem[idx(ac)] : {busy, ac};
      rd_data <= (rd_idx < 7'd80) ? mem[rd_idx] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_idx] <= wr_val;
  end

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: vector table of protocol
// transfers plus hand sequences for reset, clear, home and busy timing.
module tb_lcd_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data, lcd_dout, rd_data;
  logic       lcd_dout_en, busy;
  logic [6:0] rd_addr, ac;
  logic       disp_on, cursor_on, blink_on, inc_mode, err_busy, err_unsup;

  int checks = 0;
  int failures = 0;

  lcd_responder dut (
    .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .lcd_dout(lcd_dout), .lcd_dout_en(lcd_dout_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .ac(ac),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .inc_mode(inc_mode), .err_busy(err_busy), .err_unsup(err_unsup)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic       rw;
    logic [7:0] d;
    logic [6:0] ac;
    logic       inc;
    logic       chk;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[23];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d,
                      output logic [7:0] dout, output logic den);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    @(negedge clk);
    dout = lcd_dout; den = lcd_dout_en; lcd_e = 1'b0;
    @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle timeout actual=busy required=idle");
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic scan(input logic [6:0] a, output logic [7:0] v);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic reset_checks();
    check("rst_busy", busy, 1'b1);
    check("rst_ac", ac, 7'h00);
    check("rst_inc", inc_mode, 1'b1);
    check("rst_disp", {disp_on, cursor_on, blink_on}, 3'b000);
    check("rst_err", {err_busy, err_unsup}, 2'b00);
    check("rst_dout", lcd_dout, 8'h00);
    check("rst_rd_data", rd_data, 8'h00);
  endtask

  initial begin
    logic [7:0] v, dout;
    logic den;
    int n, bad;
    logic [6:0] a;

    tbl[0]  = '{1'b0, 1'b0, 8'h38, 7'h00, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 8'h0C, 7'h00, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 8'h06, 7'h00, 1'b1, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 8'h80, 7'h00, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 8'h31, 7'h01, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 8'h2B, 7'h02, 1'b1, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 1'b0, 8'h32, 7'h03, 1'b1, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 1'b0, 8'hA7, 7'h27, 1'b1, 1'b0, 8'h00};
    tbl[8]  = '{1'b1, 1'b0, 8'h41, 7'h40, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{1'b1, 1'b0, 8'h42, 7'h41, 1'b1, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 1'b0, 8'h04, 7'h41, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 1'b0, 8'hC0, 7'h40, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{1'b1, 1'b0, 8'h5A, 7'h27, 1'b0, 1'b0, 8'h00};
    tbl[13] = '{1'b1, 1'b1, 8'h00, 7'h26, 1'b0, 1'b1, 8'h41};
    tbl[14] = '{1'b0, 1'b0, 8'hC0, 7'h40, 1'b0, 1'b0, 8'h00};
    tbl[15] = '{1'b1, 1'b1, 8'h00, 7'h27, 1'b0, 1'b1, 8'h5A};
    tbl[16] = '{1'b0, 1'b0, 8'hB0, 7'h40, 1'b0, 1'b0, 8'h00};
    tbl[17] = '{1'b0, 1'b0, 8'hF0, 7'h00, 1'b0, 1'b0, 8'h00};
    tbl[18] = '{1'b1, 1'b1, 8'h00, 7'h67, 1'b0, 1'b1, 8'h31};
    tbl[19] = '{1'b0, 1'b0, 8'h06, 7'h67, 1'b1, 1'b0, 8'h00};
    tbl[20] = '{1'b1, 1'b1, 8'h00, 7'h00, 1'b1, 1'b1, 8'h20};
    tbl[21] = '{1'b0, 1'b0, 8'hE7, 7'h67, 1'b1, 1'b0, 8'h00};
    tbl[22] = '{1'b1, 1'b0, 8'h7E, 7'h00, 1'b1, 1'b0, 8'h00};

    rst = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
    lcd_data = 8'h00; rd_addr = 7'h00;
    repeat (3) @(negedge clk);
    reset_checks();
    rst = 1'b0;
    count_busy(n);
    check("fill_after_reset", n, 80);
    scan(7'h00, v); check("scan_00", v, 8'h20);
    scan(7'h27, v); check("scan_27", v, 8'h20);
    scan(7'h40, v); check("scan_40", v, 8'h20);
    scan(7'h67, v); check("scan_67", v, 8'h20);

    for (int i = 0; i < 23; i++) begin
      xfer(tbl[i].rs, tbl[i].rw, tbl[i].d, dout, den);
      wait_idle(200);
      check($sformatf("vec%0d_ac", i), ac, tbl[i].ac);
      check($sformatf("vec%0d_inc", i), inc_mode, tbl[i].inc);
      if (tbl[i].chk)
        check($sformatf("vec%0d_dout", i), dout, tbl[i].dout);
    end

    check("flags_disp", {disp_on, cursor_on, blink_on}, 3'b100);
    check("flags_err", {err_busy, err_unsup}, 2'b00);
    scan(7'h00, v); check("mem_00", v, 8'h31);
    scan(7'h01, v); check("mem_01", v, 8'h2B);
    scan(7'h02, v); check("mem_02", v, 8'h32);
    scan(7'h27, v); check("mem_27", v, 8'h41);
    scan(7'h40, v); check("mem_40", v, 8'h5A);
    scan(7'h67, v); check("mem_67", v, 8'h7E);

    xfer(1'b0, 1'b0, 8'h00, dout, den);
    check("nop_busy", busy, 1'b0);
    check("nop_ac", ac, 7'h00);

    xfer(1'b0, 1'b0, 8'h38, dout, den);
    count_busy(n);
    check("cmd_busy_len", n, 4);

    rd_addr = 7'h00;
    xfer(1'b1, 1'b0, 8'h99, dout, den);
    check("scan_same_cycle_old", rd_data, 8'h31);
    @(negedge clk);
    check("scan_next_new", rd_data, 8'h99);
    wait_idle(50);

    xfer(1'b0, 1'b0, 8'h85, dout, den);
    wait_idle(50);
    xfer(1'b0, 1'b0, 8'h02, dout, den);
    xfer(1'b0, 1'b1, 8'h00, dout, den);
    check("home_status_read", dout, 8'h80);
    check("home_dout_en", den, 1'b1);
    xfer(1'b1, 1'b1, 8'h00, dout, den);
    check("busy_read_ac_hold", ac, 7'h00);
    check("busy_read_no_err", err_busy, 1'b0);
    wait_idle(300);
    xfer(1'b0, 1'b0, 8'h18, dout, den);
    wait_idle(50);
    check("shift_unsup", err_unsup, 1'b1);
    check("shift_ac", ac, 7'h00);

    xfer(1'b0, 1'b0, 8'h85, dout, den);
    wait_idle(50);
    xfer(1'b0, 1'b0, 8'h01, dout, den);
    n = 0;
    while (busy && n < 400) begin
      if (n == 10) begin
        lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h77; lcd_e = 1'b1;
      end
      if (n == 11) lcd_e = 1'b0;
      @(negedge clk);
      n++;
    end
    check("clear_busy_len", n, 80);
    check("clear_err_busy", err_busy, 1'b1);
    check("clear_ac", ac, 7'h00);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      a = (i < 40) ? 7'(i) : 7'(i + 24);
      scan(a, v);
      if (v !== 8'h20) bad++;
    end
    check("clear_all_cells", bad, 0);

    xfer(1'b0, 1'b0, 8'h02, dout, den);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_checks();
    rst = 1'b0;
    count_busy(n);
    check("fill_after_mid_reset", n, 80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
